// File: rtl/counter.sv
// Free-running up-counter with count enable and a one-cycle wrap pulse.
// Both outputs come straight from registers; reset is synchronous and beats enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // Wrap fires only on the enabled edge that leaves the all-ones value.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (en_i) begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = &count_q;
        end
    end

    // Reset is tested first so an unknown enable cannot reach the registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: three widths (8, 4, 1) share one stimulus stream and are
// compared every edge against an arithmetic model of count and wrap.
module tb_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
    logic [0:0] cnt1;
    logic       wrap8, wrap4, wrap1;

    int unsigned m_cnt[3];
    bit          m_wrap[3];
    int          n_checks = 0;
    int          n_pass   = 0;

    counter #(.WIDTH(8)) u_w8 (.clk_i(clk), .rst_i(rst), .en_i(en), .count_o(cnt8), .wrap_o(wrap8));
    counter #(.WIDTH(4)) u_w4 (.clk_i(clk), .rst_i(rst), .en_i(en), .count_o(cnt4), .wrap_o(wrap4));
    counter #(.WIDTH(1)) u_w1 (.clk_i(clk), .rst_i(rst), .en_i(en), .count_o(cnt1), .wrap_o(wrap1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 1;
    endfunction

    function automatic logic [31:0] obs_cnt(input int i);
        return (i == 0) ? {24'd0, cnt8} : (i == 1) ? {28'd0, cnt4} : {31'd0, cnt1};
    endfunction

    function automatic logic obs_wrap(input int i);
        return (i == 0) ? wrap8 : (i == 1) ? wrap4 : wrap1;
    endfunction

    // Drive one edge, then advance the model: count is the number of enabled
    // edges since reset modulo 2^W; wrap marks an edge that reached a multiple of 2^W.
    task automatic step(input logic e, input logic r);
        en  = e;
        rst = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            int unsigned modulus;
            modulus = 1 << width_of(i);
            if (r === 1'b1) begin
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b0;
            end else if (e === 1'b1) begin
                m_cnt[i]  = (m_cnt[i] + 1) % modulus;
                m_wrap[i] = (m_cnt[i] == 0);
            end else begin
                m_wrap[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        step(1'bx, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_cnt(i) !== 32'd0 || obs_wrap(i) !== 1'b0)
                $display("FAIL reset w%0d: count=%0h wrap=%b, required count=0 wrap=0",
                         width_of(i), obs_cnt(i), obs_wrap(i));
            else n_pass++;
        end
    endtask

    task automatic test_enable_run;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (cnt8 !== 8'(k) || wrap8 !== 1'b0)
                $display("FAIL enable_run edge %0d: count=%0d wrap=%b, required count=%0d wrap=0",
                         k, cnt8, wrap8, k);
            else n_pass++;
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (obs_cnt(i) !== m_cnt[i] || obs_wrap(i) !== m_wrap[i])
                    $display("FAIL enable_run w%0d edge %0d: count=%0d wrap=%b, required count=%0d wrap=%b",
                             width_of(i), k, obs_cnt(i), obs_wrap(i), m_cnt[i], m_wrap[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold;
        step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (cnt8 !== 8'd5 || wrap8 !== 1'b0)
                $display("FAIL hold edge %0d: count=%0d wrap=%b, required count=5 wrap=0",
                         k, cnt8, wrap8);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b1);
        repeat (254) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if (cnt8 !== 8'd255 || wrap8 !== 1'b0)
            $display("FAIL wrap pre: count=%0d wrap=%b, required count=255 wrap=0", cnt8, wrap8);
        else n_pass++;
        step(1'b1, 1'b0);
        n_checks++;
        if (cnt8 !== 8'd0 || wrap8 !== 1'b1)
            $display("FAIL wrap edge: count=%0d wrap=%b, required count=0 wrap=1", cnt8, wrap8);
        else n_pass++;
        step(1'b0, 1'b0);
        n_checks++;
        if (cnt8 !== 8'd0 || wrap8 !== 1'b0)
            $display("FAIL wrap post: count=%0d wrap=%b, required count=0 wrap=0", cnt8, wrap8);
        else n_pass++;
        // Reset landing on the wrap edge must suppress the pulse.
        repeat (255) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (cnt8 !== 8'd0 || wrap8 !== 1'b0)
            $display("FAIL wrap reset: count=%0d wrap=%b, required count=0 wrap=0", cnt8, wrap8);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        n_checks++;
        if (cnt8 !== 8'd7)
            $display("FAIL reset_mid setup: count=%0d, required 7", cnt8);
        else n_pass++;
        step(1'b1, 1'b1);
        n_checks++;
        if (cnt8 !== 8'd0 || wrap8 !== 1'b0)
            $display("FAIL reset_mid assert: count=%0d wrap=%b, required count=0 wrap=0", cnt8, wrap8);
        else n_pass++;
        step(1'b1, 1'b0);
        n_checks++;
        if (cnt8 !== 8'd1)
            $display("FAIL reset_mid release: count=%0d, required 1", cnt8);
        else n_pass++;
    endtask

    task automatic test_width_sweep;
        int pulses1, pulses4;
        pulses1 = 0;
        pulses4 = 0;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0);
            if (wrap4 === 1'b1) pulses4++;
            if (k <= 2 && wrap1 === 1'b1) pulses1++;
            if (k == 2) begin
                n_checks++;
                if (cnt1 !== 1'b0 || pulses1 != 1)
                    $display("FAIL sweep w1: count=%0d pulses=%0d, required count=0 pulses=1", cnt1, pulses1);
                else n_pass++;
            end
        end
        n_checks++;
        if (cnt4 !== 4'd0 || pulses4 != 1)
            $display("FAIL sweep w4: count=%0d pulses=%0d, required count=0 pulses=1", cnt4, pulses4);
        else n_pass++;
        n_checks++;
        if (cnt8 !== 8'd16)
            $display("FAIL sweep w8: count=%0d, required 16", cnt8);
        else n_pass++;
    endtask

    task automatic test_random;
        step(1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            logic e, r;
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 199) == 0);
            step(e, r);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_cnt(i) !== m_cnt[i] || obs_wrap(i) !== m_wrap[i])
                    $display("FAIL random w%0d cycle %0d: count=%0d wrap=%b, required count=%0d wrap=%b",
                             width_of(i), k, obs_cnt(i), obs_wrap(i), m_cnt[i], m_wrap[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        en  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
        end
        test_reset;
        test_enable_run;
        test_hold;
        test_wrap;
        test_reset_mid;
        test_width_sweep;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
